// File: rtl/fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipe
//
// Three-stage pipelined IEEE-754 adder/subtractor for any binary format
// described by EXP_W/MAN_W. Rounds to nearest-even and reports status flags
// alongside every result.
//
// Ports (W = 1 + EXP_W + MAN_W):
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands this cycle
//   a, b       operands (packed IEEE, width W)
//   sub        0: a+b, 1: a-b
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     packed IEEE result (width W)
//   zero       result is +/-0
//   overflow   result overflowed to +/-inf
//   underflow  result was tiny and flushed to +/-0
//   invalid    NaN input or inf-inf; result is the canonical qNaN
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once out_valid is high, result and flags hold steady until
// out_ready is seen. The whole pipe advances as one unit
// (en = !out_valid | out_ready), so in_ready == en and nothing moves while
// the output is stalled; up to three items can be held in that state.
//
// Stages:
//   S1  unpack, classify, order by magnitude, align the smaller operand
//   S2  add or subtract mantissas, count leading zeros
//   S3  normalise, round nearest-even, resolve specials, pack (output regs)
// ---------------------------------------------------------------------------
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 1;          // mantissa with hidden bit
  localparam int AW  = MAN_W + 4;          // mantissa + guard/round/sticky
  localparam int SW  = MAN_W + 5;          // aligned width + carry
  localparam int LZW = $clog2(AW + 1);
  localparam logic [31:0] EXP_MAX = 32'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;

  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // -------------------------------------------------------------------------
  // S1: unpack / classify / align
  // -------------------------------------------------------------------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [W-2:0]     mag_a, mag_b;
  logic             swap;
  logic             x_sign, y_sign;
  logic [EXP_W-1:0] x_exp, y_exp;
  logic [MW-1:0]    x_man, y_man;
  logic [31:0]      diff;
  logic [AW-1:0]    y_ext, y_mask, y_al;

  assign sa = a[W-1];
  assign ea = a[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  // Subtraction is folded into b's sign once, here.
  assign sb = b[W-1] ^ sub;
  assign eb = b[W-2:MAN_W];
  assign fb = b[MAN_W-1:0];

  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  // Exponent field 0 covers both true zero and subnormals; both act as zero.
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  // Magnitude order on {exp, frac}; flushed subnormals rank as zero.
  assign mag_a = a_zero ? {(W-1){1'b0}} : a[W-2:0];
  assign mag_b = b_zero ? {(W-1){1'b0}} : b[W-2:0];
  assign swap  = mag_b > mag_a;

  always_comb begin
    x_sign = sa;
    y_sign = sb;
    x_exp  = ea;
    y_exp  = eb;
    x_man  = a_zero ? {MW{1'b0}} : {1'b1, fa};
    y_man  = b_zero ? {MW{1'b0}} : {1'b1, fb};
    if (swap) begin
      x_sign = sb;
      y_sign = sa;
      x_exp  = eb;
      y_exp  = ea;
      x_man  = b_zero ? {MW{1'b0}} : {1'b1, fb};
      y_man  = a_zero ? {MW{1'b0}} : {1'b1, fa};
    end

    // x_exp >= y_exp whenever y is non-zero; when y is zero its mantissa is
    // zero and the (possibly wrapped) distance is harmless.
    diff   = 32'(x_exp) - 32'(y_exp);
    y_ext  = {y_man, 3'b000};
    y_mask = '0;
    y_al   = '0;
    if (diff >= 32'(AW)) begin
      // Entire mantissa falls below the sticky position.
      y_al = {{(AW-1){1'b0}}, |y_man};
    end else begin
      y_mask  = ~({AW{1'b1}} << diff);
      y_al    = y_ext >> diff;
      y_al[0] = y_al[0] | (|(y_ext & y_mask));
    end
  end

  logic             s1_valid;
  logic             s1_nan, s1_inf, s1_inf_sign, s1_zsign;
  logic             s1_sign, s1_eff_sub;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_xman;
  logic [AW-1:0]    s1_yal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_nan      <= 1'b0;
      s1_inf      <= 1'b0;
      s1_inf_sign <= 1'b0;
      s1_zsign    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_eff_sub  <= 1'b0;
      s1_exp      <= '0;
      s1_xman     <= '0;
      s1_yal      <= '0;
    end else if (en) begin
      s1_valid    <= in_valid;
      // inf + (-inf) in effective terms is invalid just like a NaN operand.
      s1_nan      <= a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
      s1_inf      <= a_inf | b_inf;
      s1_inf_sign <= a_inf ? sa : sb;
      // An exact zero sum is -0 only when both effective operands are -0.
      s1_zsign    <= a_zero & b_zero & sa & sb;
      s1_sign     <= x_sign;
      s1_eff_sub  <= x_sign ^ y_sign;
      s1_exp      <= x_exp;
      s1_xman     <= x_man;
      s1_yal      <= y_al;
    end
  end

  // -------------------------------------------------------------------------
  // S2: add / subtract and leading-zero count
  // -------------------------------------------------------------------------
  function automatic logic [LZW-1:0] lzc_f(input logic [AW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  logic [SW-1:0]  x_ext2, y_ext2, sum_n;
  logic [LZW-1:0] lzc_n;

  assign x_ext2 = {1'b0, s1_xman, 3'b000};
  assign y_ext2 = {1'b0, s1_yal};
  // X has the larger magnitude, so the difference never goes negative.
  assign sum_n  = s1_eff_sub ? (x_ext2 - y_ext2) : (x_ext2 + y_ext2);
  assign lzc_n  = lzc_f(sum_n[AW-1:0]);

  logic             s2_valid;
  logic             s2_nan, s2_inf, s2_inf_sign, s2_zsign, s2_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;
  logic [LZW-1:0]   s2_lzc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_nan      <= 1'b0;
      s2_inf      <= 1'b0;
      s2_inf_sign <= 1'b0;
      s2_zsign    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
      s2_lzc      <= '0;
    end else if (en) begin
      s2_valid    <= s1_valid;
      s2_nan      <= s1_nan;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
      s2_zsign    <= s1_zsign;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_n;
      s2_lzc      <= lzc_n;
    end
  end

  // -------------------------------------------------------------------------
  // S3: normalise / round / specials / pack
  // -------------------------------------------------------------------------
  logic          carry;
  logic [31:0]   lz32, cap32, sh32, e_work, e_fin;
  logic [AW-1:0] norm;
  logic          rup;
  logic [MW:0]   rnd;
  logic [MW-1:0] man_f;
  logic [W-1:0]  res_n;
  logic          zero_n, ovf_n, unf_n, inv_n;

  always_comb begin
    carry  = s2_sum[SW-1];
    lz32   = 32'(s2_lzc);
    cap32  = 32'(s2_exp) - 32'd1;
    sh32   = '0;
    norm   = '0;
    e_work = '0;
    if (carry) begin
      // Sum reached 2.0: drop one bit into sticky and bump the exponent.
      norm    = s2_sum[SW-1:1];
      norm[0] = s2_sum[1] | s2_sum[0];
      e_work  = 32'(s2_exp) + 32'd1;
    end else begin
      // Left shift is capped so the biased exponent never goes below 1; a
      // result that still lacks its hidden bit afterwards is tiny.
      sh32   = (lz32 < cap32) ? lz32 : cap32;
      norm   = s2_sum[AW-1:0] << sh32;
      e_work = 32'(s2_exp) - sh32;
    end

    // norm = {mantissa[MW-1:0], guard, round, sticky}
    rup = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[AW-1:3]} + {{MW{1'b0}}, rup};
    if (rnd[MW]) begin
      man_f = rnd[MW:1];
      e_fin = e_work + 32'd1;
    end else begin
      man_f = rnd[MW-1:0];
      e_fin = e_work;
    end

    res_n  = '0;
    zero_n = 1'b0;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    inv_n  = 1'b0;
    if (s2_nan) begin
      res_n = QNAN;
      inv_n = 1'b1;
    end else if (s2_inf) begin
      res_n = {s2_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (~(|s2_sum)) begin
      res_n  = {s2_zsign, {(W-1){1'b0}}};
      zero_n = 1'b1;
    end else if (e_fin >= EXP_MAX) begin
      res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else if (!man_f[MW-1]) begin
      res_n  = {s2_sign, {(W-1){1'b0}}};
      unf_n  = 1'b1;
      zero_n = 1'b1;
    end else begin
      res_n = {s2_sign, e_fin[EXP_W-1:0], man_f[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (en) begin
      // Bubbles leave result and flags at zero.
      out_valid <= s2_valid;
      result    <= s2_valid ? res_n : '0;
      zero      <= s2_valid & zero_n;
      overflow  <= s2_valid & ovf_n;
      underflow <= s2_valid & unf_n;
      invalid   <= s2_valid & inv_n;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_pipe
//
// Directed bench for fp_addsub_pipe: one single-precision instance and one
// half-precision instance (EXP_W=5, MAN_W=10). Expected results are hand
// computed constants. Inputs are driven and outputs sampled on the falling
// edge. Prints one summary line at the end.
// ---------------------------------------------------------------------------
module tb_fp_addsub_pipe;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // single-precision instance
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic        zero, overflow, underflow, invalid;
  logic [31:0] a, b, result;

  // half-precision instance
  logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
  logic        h_zero, h_overflow, h_underflow, h_invalid;
  logic [15:0] h_a, h_b, h_result;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow),
    .underflow(underflow), .invalid(invalid)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .sub(h_sub),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .zero(h_zero), .overflow(h_overflow),
    .underflow(h_underflow), .invalid(h_invalid)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One isolated operation; checks 3-cycle latency, result and flags.
  // Flags are packed {zero, overflow, underflow, invalid}.
  task automatic run_op(input string tag, input bit half,
                        input logic [31:0] ta, input logic [31:0] tbv,
                        input logic tsub, input logic [31:0] exp_r,
                        input logic [3:0] exp_f);
    int          lat;
    logic        ov;
    logic [31:0] obs_r;
    logic [3:0]  obs_f;
    @(negedge clk);
    out_ready   = 1'b1;
    h_out_ready = 1'b1;
    if (half) begin
      h_a = ta[15:0]; h_b = tbv[15:0]; h_sub = tsub; h_in_valid = 1'b1;
    end else begin
      a = ta; b = tbv; sub = tsub; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
    lat = 1;
    ov  = half ? h_out_valid : out_valid;
    while (!ov && lat < 10) begin
      @(negedge clk);
      lat++;
      ov = half ? h_out_valid : out_valid;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    obs_r = half ? {16'h0, h_result} : result;
    obs_f = half ? {h_zero, h_overflow, h_underflow, h_invalid}
                 : {zero, overflow, underflow, invalid};
    check({tag, "_result"}, obs_r, exp_r);
    check({tag, "_flags"}, {28'h0, obs_f}, {28'h0, exp_f});
  endtask

  // backpressure stimulus table
  logic [31:0] bp_a[5], bp_b[5], bp_r[5];

  initial begin
    int accepted, received, cyc;

    // 1.0+1.0=2, 2+1=3, 3+1=4, 4+1=5, 5+1=6
    bp_a[0] = 32'h3F800000; bp_b[0] = 32'h3F800000; bp_r[0] = 32'h40000000;
    bp_a[1] = 32'h40000000; bp_b[1] = 32'h3F800000; bp_r[1] = 32'h40400000;
    bp_a[2] = 32'h40400000; bp_b[2] = 32'h3F800000; bp_r[2] = 32'h40800000;
    bp_a[3] = 32'h40800000; bp_b[3] = 32'h3F800000; bp_r[3] = 32'h40A00000;
    bp_a[4] = 32'h40A00000; bp_b[4] = 32'h3F800000; bp_r[4] = 32'h40C00000;

    rst_n = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_out_ready = 1'b1;

    // reset state, asserted before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'h0, zero, overflow, underflow, invalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);

    // main function
    run_op("add_3p75",   0, 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'b0000);
    run_op("sub_same",   0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b1000);
    run_op("negz",       0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b1000);
    run_op("tie_even",   0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000);
    run_op("tie_up",     0, 32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'b0000);
    run_op("sub_2m1",    0, 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);
    run_op("sub_neg",    0, 32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000);
    run_op("sub_sticky", 0, 32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 4'b0000);
    run_op("subn_in",    0, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    // specials
    run_op("ovf",        0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100);
    run_op("inf_m_inf",  0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001);
    run_op("nan_in",     0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001);
    run_op("inf_p_one",  0, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    run_op("unf",        0, 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b1010);
    // half-precision instance
    run_op("h_add",      1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 4'b0000);
    run_op("h_ovf",      1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 4'b0100);

    // backpressure: stall output, offer 5 back-to-back pairs
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      a = bp_a[accepted]; b = bp_b[accepted]; sub = 1'b0; in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back(bp_r[accepted]);
        accepted++;
      end
      @(negedge clk);
    end
    check("bp_accepted", 32'(accepted), 32'd3);
    check("bp_in_ready", {31'h0, in_ready}, 32'd0);
    check("bp_out_valid", {31'h0, out_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("bp_stable", result, exp_q[0]);
      @(negedge clk);
    end

    // release and drain, results in order
    out_ready = 1'b1;
    #1;
    received = 0;
    cyc = 0;
    while (received < 5 && cyc < 40) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_output", {31'h0, out_valid}, 32'd0);
        end else begin
          check("bp_order", result, exp_q.pop_front());
        end
        received++;
      end
      if (accepted < 5) begin
        a = bp_a[accepted]; b = bp_b[accepted]; sub = 1'b0; in_valid = 1'b1;
        if (in_ready) begin
          exp_q.push_back(bp_r[accepted]);
          accepted++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_received", 32'(received), 32'd5);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("bp_no_dup", {31'h0, out_valid}, 32'd0);

    // reset with three items in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = bp_a[k]; b = bp_b[k]; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid_pre_valid", {31'h0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mid_in_ready", {31'h0, in_ready}, 32'd1);
    run_op("post_rst", 0, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 adder/subtractor, successor to the combinational adder_floating_point.
- Supports any binary format via EXP_W/MAN_W and selects add or subtract per transaction.
- Uses valid/ready flow control on input and output, rounds to nearest-even, and reports status flags per result.
- Sits between operand FIFOs and the result writeback in the FP datapath.

Parameters:
- EXP_W, 8, exponent field width (>=3)
- MAN_W, 23, stored fraction width (>=2). Word width W = 1+EXP_W+MAN_W (32 at default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- a  in  W  operand A
- b  in  W  operand B
- sub  in  1  0: a+b, 1: a-b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  packed IEEE result
- zero  out  1  result is +/-0
- overflow  out  1  result overflowed to +/-inf
- underflow  out  1  result was tiny and flushed to +/-0
- invalid  out  1  NaN input or inf-inf; result is canonical qNaN

Behaviour:
- Reset: all stage valid bits, out_valid, result, zero, overflow, underflow and invalid go to 0 immediately on rst_n low. Reset mid-stream discards all in-flight items.
- Global advance: en = !out_valid | out_ready.
  - in_ready = en.
  - Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
  - On en, every stage register (data + valid) shifts by one. Otherwise all registers hold.
  - Outputs are registers and stay stable while out_valid=1 & out_ready=0.
- Latency and throughput: an accepted pair appears on result exactly 3 cycles later with no stall, at 1 op/cycle. With output stalled, at most 3 items are held; in_ready=0 while stalled.
- S1 (unpack/align):
  - Effective sign of b = b.sign ^ sub.
  - Classify NaN / inf / zero. Subnormal inputs are treated as signed zero.
  - Restore hidden 1 and swap so operand X has the larger magnitude (exponent, then fraction).
  - Right-shift Y by the exponent difference into MAN_W+1 bits plus guard, round and sticky. Shifts >= MAN_W+3 leave only sticky.
- S2 (add):
  - Same effective signs: add. Otherwise subtract Y from X.
  - Compute the leading-zero count of the sum.
- S3 (normalize/round/pack):
  - Carry out: shift right 1, exp+1, fold the dropped bit into sticky.
  - Otherwise shift left by the lzc, capped so biased exp stays >= 1.
  - Round nearest-even on guard/round/sticky. A rounding carry renormalises and increments exp.
- Specials, in priority order:
  - Any NaN, or inf + (-inf) effective: result {0, all-ones exp, 1 followed by zeros}, invalid=1.
  - Any inf otherwise: that inf.
  - Exact zero sum: +0, except both effective operands -0 gives -0.
  - Biased exp >= 2^EXP_W-1 after rounding: signed inf, overflow=1.
  - Biased exp < 1 (tiny): signed zero, underflow=1, zero=1.
- Flags are mutually exclusive except zero with underflow. Flags are valid only with out_valid.

Test Plan:
- a=0x3FC00000, b=0x40100000, sub=0 -> result 0x40700000 (3.75), all flags 0, out_valid 3 cycles after accept.
- a=0x3F800000, b=0x3F800000, sub=1 -> 0x00000000, zero=1. a=0x80000000, b=0x00000000, sub=1 -> 0x80000000, zero=1.
- Rounding ties:
  - a=0x3F800000, b=0x33800000, sub=0 -> 0x3F800000 (tie to even).
  - b=0x34400000 -> 0x3F800002.
- Specials:
  - a=0x7F7FFFFF, b=0x7F7FFFFF, sub=0 -> 0x7F800000, overflow=1.
  - a=0x7F800000, b=0x7F800000, sub=1 -> 0x7FC00000, invalid=1.
  - a=0x00800000, b=0x00800001, sub=1 -> 0x80000000, underflow=1, zero=1.
- Backpressure:
  - Hold out_ready=0 and offer 5 back-to-back pairs -> exactly 3 accepted, in_ready=0 after that, result stable.
  - Release out_ready -> all 5 results in order, no loss or duplication.
- Drive rst_n=0 with 3 items in flight -> out_valid=0 immediately. After release, the first new op completes with correct 3-cycle latency and no stale results.
- EXP_W=5, MAN_W=10 instance: 0x3C00+0x3C00 -> 0x4000, 0x7BFF+0x7BFF -> 0x7C00 with overflow=1.
